// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt pending arbiter: default sizes, ID width helper, FSM states.
package interrupt_pkg;

   localparam int N_INTERRUPTS_DEF = 32;
   localparam int PRIO_W_DEF       = 3;

   function automatic int id_width(input int n_sources);
      return $clog2(n_sources + 1);
   endfunction

   typedef enum logic {
      IDLE      = 1'b0,
      SERVICING = 1'b1
   } arb_state_t;

endpackage

// File: rtl/interrupt_pending_arbiter_priority_select.sv
// Combinational max-priority selector; ties resolve to the lowest source index. ID 0 means none.
module priority_select
   import interrupt_pkg::*;
#(
   parameter int N_interrupts = N_INTERRUPTS_DEF,
   parameter int PRIO_W       = PRIO_W_DEF,
   parameter int ID_W         = id_width(N_interrupts)
) (
   input  logic [N_interrupts-1:0]        eligible,
   input  logic [N_interrupts*PRIO_W-1:0] prio_flat,
   output logic [ID_W-1:0]                best_id
);

   logic [PRIO_W-1:0] best_prio;
   logic              found;

   // Strict '>' keeps the earliest (lowest-index) source on equal priority.
   always_comb begin
      best_prio = '0;
      found     = 1'b0;
      best_id   = '0;
      for (int i = 0; i < N_interrupts; i++) begin
         if (eligible[i] && (!found || (prio_flat[i*PRIO_W +: PRIO_W] > best_prio))) begin
            found     = 1'b1;
            best_prio = prio_flat[i*PRIO_W +: PRIO_W];
            best_id   = ID_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/interrupt_pending_arbiter.sv
// Pending-bit latch, priority arbitration and single-context claim/complete handshake.
module interrupt_pending_arbiter
   import interrupt_pkg::*;
#(
   parameter int N_interrupts = N_INTERRUPTS_DEF,
   parameter int PRIO_W       = PRIO_W_DEF,
   parameter int ID_W         = id_width(N_interrupts)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_interrupts-1:0]        interrupt_requests,
   input  logic [N_interrupts-1:0]        interrupt_enable,
   input  logic [N_interrupts*PRIO_W-1:0] interrupt_priority,
   input  logic [PRIO_W-1:0]              priority_threshold,
   input  logic                           claim,
   input  logic                           complete,
   input  logic [ID_W-1:0]                complete_id,
   output logic                           irq,
   output logic [ID_W-1:0]                irq_id,
   output logic [ID_W-1:0]                active_id,
   output logic [N_interrupts-1:0]        pending,
   output logic                           complete_err
);

   arb_state_t              state_q, state_d;
   logic [N_interrupts-1:0] pending_q, pending_d;
   logic [ID_W-1:0]         active_id_q, active_id_d;
   logic [ID_W-1:0]         irq_id_q, irq_id_d;
   logic                    irq_q, irq_d;
   logic                    complete_err_q, complete_err_d;
   logic [N_interrupts-1:0] eligible;
   logic [ID_W-1:0]         best_id;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < N_interrupts; i++) begin
         eligible[i] = pending_q[i] && interrupt_enable[i]
                       && (interrupt_priority[i*PRIO_W +: PRIO_W] > priority_threshold)
                       && (interrupt_priority[i*PRIO_W +: PRIO_W] != '0);
      end
   end

   priority_select #(
      .N_interrupts (N_interrupts),
      .PRIO_W       (PRIO_W),
      .ID_W         (ID_W)
   ) u_priority_select (
      .eligible  (eligible),
      .prio_flat (interrupt_priority),
      .best_id   (best_id)
   );

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      active_id_d    = active_id_q;
      complete_err_d = 1'b0;
      irq_d          = (state_q == IDLE) && (best_id != '0);
      irq_id_d       = (state_q == IDLE) ? best_id : '0;
      unique case (state_q)
         IDLE: begin
            // Claim acts on the registered ID: exactly what the core read.
            if (claim && (irq_id_q != '0)) begin
               for (int i = 0; i < N_interrupts; i++) begin
                  if (irq_id_q == ID_W'(i + 1)) pending_d[i] = 1'b0;
               end
               active_id_d = irq_id_q;
               state_d     = SERVICING;
            end
            if (complete) complete_err_d = 1'b1;
         end
         SERVICING: begin
            if (complete) begin
               if (complete_id == active_id_q) begin
                  active_id_d = '0;
                  state_d     = IDLE;
               end else begin
                  complete_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A new edge in the claim cycle must survive the clear.
      pending_d = pending_d | interrupt_requests;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pending_q      <= '0;
         active_id_q    <= '0;
         irq_id_q       <= '0;
         irq_q          <= 1'b0;
         complete_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         active_id_q    <= active_id_d;
         irq_id_q       <= irq_id_d;
         irq_q          <= irq_d;
         complete_err_q <= complete_err_d;
      end
   end

   assign irq          = irq_q;
   assign irq_id       = irq_id_q;
   assign active_id    = active_id_q;
   assign pending      = pending_q;
   assign complete_err = complete_err_q;

endmodule

// File: tb/tb_interrupt_pending_arbiter.sv
// Self-checking bench: directed table, corner-case sequences and randomized run against a reference model.
module tb_interrupt_pending_arbiter;

   localparam int N    = 32;
   localparam int PW   = 3;
   localparam int ID_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [N-1:0]      en;
   logic [N*PW-1:0]   prio;
   logic [PW-1:0]     thr;
   logic              claim;
   logic              complete;
   logic [ID_W-1:0]   cid;
   logic              irq;
   logic [ID_W-1:0]   irq_id;
   logic [ID_W-1:0]   active_id;
   logic [N-1:0]      pending;
   logic              complete_err;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   bit [N-1:0] m_pend;
   int         m_active;
   bit         m_idle;
   bit         m_irq;
   int         m_irq_id;
   bit         m_err;

   interrupt_pending_arbiter dut (
      .clk                (clk),
      .rst                (rst),
      .interrupt_requests (req),
      .interrupt_enable   (en),
      .interrupt_priority (prio),
      .priority_threshold (thr),
      .claim              (claim),
      .complete           (complete),
      .complete_id        (cid),
      .irq                (irq),
      .irq_id             (irq_id),
      .active_id          (active_id),
      .pending            (pending),
      .complete_err       (complete_err)
   );

   always #5 clk = ~clk;

   function automatic int prio_of(input int i);
      return int'(prio[i*PW +: PW]);
   endfunction

   // Highest eligible priority first, then the first source holding it.
   function automatic int model_best();
      int mx = 0;
      for (int i = 0; i < N; i++)
         if (m_pend[i] && en[i] && prio_of(i) > int'(thr) && prio_of(i) > mx) mx = prio_of(i);
      if (mx == 0) return 0;
      for (int i = 0; i < N; i++)
         if (m_pend[i] && en[i] && prio_of(i) == mx) return i + 1;
      return 0;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_prio(input int i, input int p);
      prio[i*PW +: PW] = PW'(p);
   endtask

   // Advance one clock; the model consumes the same inputs, then DUT and model are compared.
   task automatic step(input string tag);
      int best;
      bit [N-1:0] n_pend;
      int n_active, n_id;
      bit n_idle, n_irq, n_err;
      best = model_best();
      if (rst) begin
         n_pend = '0; n_active = 0; n_idle = 1; n_irq = 0; n_id = 0; n_err = 0;
      end else begin
         n_irq    = m_idle && best != 0;
         n_id     = m_idle ? best : 0;
         n_err    = complete && (m_idle || int'(cid) != m_active);
         n_pend   = m_pend;
         n_active = m_active;
         n_idle   = m_idle;
         if (m_idle && claim && m_irq_id != 0) begin
            n_pend[m_irq_id-1] = 1'b0;
            n_active = m_irq_id;
            n_idle = 0;
         end else if (!m_idle && complete && int'(cid) == m_active) begin
            n_active = 0;
            n_idle = 1;
         end
         n_pend = n_pend | req;
      end
      @(posedge clk);
      #1;
      m_pend = n_pend; m_active = n_active; m_idle = n_idle;
      m_irq = n_irq; m_irq_id = n_id; m_err = n_err;
      vectors++;
      if (irq !== m_irq || int'(irq_id) != m_irq_id || int'(active_id) != m_active
          || pending !== m_pend || complete_err !== m_err) begin
         miscompares++;
         $display("FAIL model %s: irq=%0b id=%0d act=%0d pend=%h err=%0b, expected irq=%0b id=%0d act=%0d pend=%h err=%0b",
                  tag, irq, irq_id, active_id, pending, complete_err,
                  m_irq, m_irq_id, m_active, m_pend, m_err);
      end
      req = '0; claim = 1'b0; complete = 1'b0; rst = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step("reset");
   endtask

   typedef struct {
      logic [N-1:0] req;
      bit           claim;
      bit           cmp;
      int           cid;
      bit           e_irq;
      int           e_id;
      int           e_act;
      logic [N-1:0] e_pend;
      bit           e_err;
   } vec_t;

   vec_t tbl[8];

   initial begin
      rst = 1'b1; req = '0; en = '1; prio = '0; thr = '0;
      claim = 1'b0; complete = 1'b0; cid = '0;

      // Reset state
      step("reset");
      chk("reset_irq", irq, 0);
      chk("reset_irq_id", irq_id, 0);
      chk("reset_active", active_id, 0);
      chk("reset_pending", pending, 0);
      chk("reset_err", complete_err, 0);

      // Source 4, prio 3: latch, irq, claim, mismatched and matched complete, complete in IDLE
      set_prio(4, 3);
      tbl[0] = '{32'h10, 0, 0, 0, 0, 0, 0, 32'h10, 0};
      tbl[1] = '{32'h0,  0, 0, 0, 1, 5, 0, 32'h10, 0};
      tbl[2] = '{32'h0,  1, 0, 0, 1, 5, 5, 32'h0,  0};
      tbl[3] = '{32'h0,  0, 0, 0, 0, 0, 5, 32'h0,  0};
      tbl[4] = '{32'h0,  0, 1, 6, 0, 0, 5, 32'h0,  1};
      tbl[5] = '{32'h0,  0, 1, 5, 0, 0, 0, 32'h0,  0};
      tbl[6] = '{32'h0,  0, 1, 0, 0, 0, 0, 32'h0,  1};
      tbl[7] = '{32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  0};
      for (int r = 0; r < 8; r++) begin
         req = tbl[r].req; claim = tbl[r].claim; complete = tbl[r].cmp; cid = ID_W'(tbl[r].cid);
         step($sformatf("tbl%0d", r));
         vectors++;
         if (irq !== tbl[r].e_irq || int'(irq_id) != tbl[r].e_id || int'(active_id) != tbl[r].e_act
             || pending !== tbl[r].e_pend || complete_err !== tbl[r].e_err) begin
            miscompares++;
            $display("FAIL row%0d: irq=%0b id=%0d act=%0d pend=%h err=%0b, expected irq=%0b id=%0d act=%0d pend=%h err=%0b",
                     r, irq, irq_id, active_id, pending, complete_err, tbl[r].e_irq,
                     tbl[r].e_id, tbl[r].e_act, tbl[r].e_pend, tbl[r].e_err);
         end
      end

      // Priority and tie: sources 2,7 prio 5, source 9 prio 6
      do_reset(); prio = '0; set_prio(2, 5); set_prio(7, 5); set_prio(9, 6);
      req = (32'h1 << 2) | (32'h1 << 7) | (32'h1 << 9);
      step("tie_p"); step("tie_w");
      chk("tie_first", irq_id, 10);
      claim = 1'b1; step("tie_c10"); step("tie_s");
      complete = 1'b1; cid = 6'd10; step("tie_d10"); step("tie_w2");
      chk("tie_second", irq_id, 3);
      claim = 1'b1; step("tie_c3"); step("tie_s2");
      complete = 1'b1; cid = 6'd3; step("tie_d3"); step("tie_w3");
      chk("tie_third", irq_id, 8);

      // Threshold: source 1 prio 2 blocked at threshold 2, passes at 1
      do_reset(); prio = '0; set_prio(1, 2); thr = 3'd2;
      req = 32'h2; step("thr_p"); step("thr_w1"); step("thr_w2");
      chk("thr_block", irq, 0);
      thr = 3'd1; step("thr_w3"); step("thr_w4");
      chk("thr_pass_irq", irq, 1);
      chk("thr_pass_id", irq_id, 2);
      thr = '0;

      // Re-pulse during service and in the claim cycle itself
      do_reset(); prio = '0; set_prio(3, 4);
      req = 32'h8; step("rp_p"); step("rp_w");
      chk("rp_id", irq_id, 4);
      claim = 1'b1; req = 32'h8; step("rp_claim");
      chk("rp_pend_kept", pending[3], 1);
      chk("rp_active", active_id, 4);
      step("rp_s"); req = 32'h8; step("rp_again");
      complete = 1'b1; cid = 6'd4; step("rp_done"); step("rp_w2");
      chk("rp_reassert_irq", irq, 1);
      chk("rp_reassert_id", irq_id, 4);

      // Disabled source keeps pending; reset mid-service clears everything
      do_reset(); prio = '0;
      set_prio(0, 1); set_prio(1, 2); set_prio(5, 3); set_prio(10, 1); set_prio(12, 1);
      en = ~(32'h1 << 5);
      req = 32'h1 | 32'h2 | (32'h1 << 5) | (32'h1 << 10);
      step("rs_p"); step("rs_w");
      chk("rs_first", irq_id, 2);
      claim = 1'b1; step("rs_c2"); step("rs_s");
      complete = 1'b1; cid = 6'd2; step("rs_d2"); step("rs_w2");
      chk("rs_low_idx", irq_id, 1);
      chk("rs_dis_pend", pending[5], 1);
      en = '1; step("rs_en1"); step("rs_en2");
      chk("rs_reenable", irq_id, 6);
      claim = 1'b1; step("rs_c6");
      req = 32'h1 << 12; step("rs_p12");
      chk("rs_active", active_id, 6);
      chk("rs_three", $countones(pending), 3);
      rst = 1'b1; step("rs_rst");
      chk("rs_pend0", pending, 0);
      chk("rs_irq0", irq, 0);
      chk("rs_act0", active_id, 0);
      step("rs_after");
      chk("rs_idle_irq", irq, 0);

      // Randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) begin
            prio = {$urandom, $urandom, $urandom};
            thr  = PW'($urandom_range(0, 3));
            en   = $urandom | $urandom;
         end
         req      = $urandom & $urandom & $urandom & $urandom;
         claim    = ($urandom_range(0, 5) == 0);
         complete = ($urandom_range(0, 7) == 0);
         cid      = $urandom_range(0, 1) ? ID_W'(m_active) : ID_W'($urandom_range(0, 32));
         rst      = ($urandom_range(0, 299) == 0);
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
